// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, flag and handshake controller for an 8x10 FIFO memory.
// Optional sticky overflow/underflow detection is enabled by defining
// FIFO_CTRL_ERR_EN; without it err_o is tied low and no detection logic exists.
module fifo_ctrl #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int PTR_W     = 4,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    output logic              mem_wr_en_o,
    output logic              mem_rd_en_o,
    output logic [PTR_W-1:0]  mem_wr_ptr_o,
    output logic [PTR_W-1:0]  mem_rd_ptr_o,
    output logic              data_valid_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_NORMAL = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_THRESH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                data_valid_q;
    logic                push_ok, pop_ok;

    // Flags decode straight from registered state/count.
    assign full_o         = (state_q == ST_FULL);
    assign empty_o        = (state_q == ST_EMPTY);
    assign almost_full_o  = (count_q >= AF_LVL);
    assign almost_empty_o = (count_q <= AE_LVL);
    assign count_o        = count_q;
    assign data_valid_o   = data_valid_q;

    // A push into a full FIFO is legal only when a pop frees the slot in the
    // same cycle (memory reads the old word before the write lands).
    // Reset overrides any same-cycle request.
    assign push_ok = push_i & (~full_o | pop_i) & ~reset_i;
    assign pop_ok  = pop_i & ~empty_o & ~reset_i;

    assign mem_wr_en_o  = push_ok;
    assign mem_rd_en_o  = pop_ok;
    assign mem_wr_ptr_o = {{(PTR_W-ADDR_W){1'b0}}, wr_addr_q};
    assign mem_rd_ptr_o = {{(PTR_W-ADDR_W){1'b0}}, rd_addr_q};

    // Next-state: pointers wrap naturally at DEPTH, count and occupancy FSM.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q + ADDR_W'(push_ok);
        rd_addr_d = rd_addr_q + ADDR_W'(pop_ok);
        count_d   = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        unique case (state_q)
            ST_EMPTY: begin
                if (push_ok) state_d = ST_NORMAL;
            end
            ST_NORMAL: begin
                if (count_q == CNT_LAST && push_ok && !pop_ok)
                    state_d = ST_FULL;
                else if (count_q == CNT_ONE && pop_ok && !push_ok)
                    state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (pop_ok && !push_ok) state_d = ST_NORMAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, pointer, count and read-valid registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_EMPTY;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            count_q      <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            count_q      <= count_d;
            data_valid_q <= pop_ok;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic err_q;

    // Sticky error: overflow (push dropped) or underflow (pop on empty).
    always_ff @(posedge clk_i) begin
        if (reset_i)
            err_q <= 1'b0;
        else if ((push_i & ~push_ok) | (pop_i & empty_o))
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // CNT_FULL documents the upper bound of count; it never needs decoding
    // because FULL is tracked by the state register.
    logic unused_cnt_full;
    assign unused_cnt_full = ^CNT_FULL;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed-vector bench for fifo_ctrl with a behavioural 8x10
// memory (registered read data) attached to the controller's ports.
module tb_fifo_ctrl;

`ifdef FIFO_CTRL_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, push, pop;
    logic       wr_en, rd_en, dv, full, empty, af, ae, err;
    logic [3:0] wr_ptr, rd_ptr, count;
    logic [9:0] din, dout;
    logic [9:0] mem [0:7];

    int nvec = 0;
    int nerr = 0;

    fifo_ctrl dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .push_i         (push),
        .pop_i          (pop),
        .mem_wr_en_o    (wr_en),
        .mem_rd_en_o    (rd_en),
        .mem_wr_ptr_o   (wr_ptr),
        .mem_rd_ptr_o   (rd_ptr),
        .data_valid_o   (dv),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (af),
        .almost_empty_o (ae),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read of the old word.
    always @(posedge clk) begin
        if (wr_en) mem[wr_ptr[2:0]] <= din;
        if (rd_en) dout <= mem[rd_ptr[2:0]];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic pu, input logic po, input logic [9:0] d);
        reset = r; push = pu; pop = po; din = d;
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst.empty", empty, 1);
        chk("rst.ae",    ae,    1);
        chk("rst.full",  full,  0);
        chk("rst.af",    af,    0);
        chk("rst.count", count, 0);
        chk("rst.wrptr", wr_ptr, 0);
        chk("rst.rdptr", rd_ptr, 0);
        chk("rst.dv",    dv,    0);
        chk("rst.err",   err,   0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
        @(negedge clk);
        tick();
        drive(0, 0, 0, 0);
        tick(); tick();
        chk_reset_vals();

        // Fill 8 words 0x001..0x008.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 10'(i + 1));
            chk("fill.wren", wr_en, 1);
            chk("fill.wrptr", wr_ptr, i);
            tick();
            chk("fill.count", count, i + 1);
            chk("fill.full",  full, (i == 7) ? 1 : 0);
            chk("fill.af",    af, (i + 1 >= 6) ? 1 : 0);
            chk("fill.ae",    ae, (i + 1 <= 2) ? 1 : 0);
            chk("fill.empty", empty, 0);
        end

        // Drain 8 words; data_valid continuous and data in order.
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 0);
            chk("drain.rden", rd_en, 1);
            chk("drain.rdptr", rd_ptr, i);
            tick();
            chk("drain.dv",    dv, 1);
            chk("drain.data",  dout, i + 1);
            chk("drain.count", count, 7 - i);
            chk("drain.empty", empty, (i == 7) ? 1 : 0);
        end
        drive(0, 0, 0, 0);
        tick();
        chk("idle.dv", dv, 0);

        // Refill with 0x011..0x018 (pointers wrapped back to 0).
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 10'(8'h11 + i));
            tick();
        end
        chk("refill.full", full, 1);

        // Push+pop while full: stays full, oldest word out, pointers wrap.
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 1, 10'(8'h21 + k));
            chk("pp.wren", wr_en, 1);
            chk("pp.rden", rd_en, 1);
            chk("pp.wrptr", wr_ptr, k % 8);
            chk("pp.rdptr", rd_ptr, k % 8);
            tick();
            chk("pp.count", count, 8);
            chk("pp.full",  full, 1);
            chk("pp.dv",    dv, 1);
            chk("pp.data",  dout, (k < 8) ? (8'h11 + k) : (8'h21 + k - 8));
        end

        // Drain the rotated contents 0x023..0x02A.
        for (int j = 0; j < 8; j++) begin
            drive(0, 0, 1, 0);
            tick();
            chk("rot.data", dout, 8'h23 + j);
        end
        chk("rot.empty", empty, 1);
        chk("rot.wrptr", wr_ptr, 2);
        chk("rot.rdptr", rd_ptr, 2);

        // Pop on empty with simultaneous push: only push accepted.
        drive(0, 1, 1, 10'h055);
        chk("pe.rden", rd_en, 0);
        chk("pe.wren", wr_en, 1);
        tick();
        chk("pe.count", count, 1);
        chk("pe.dv",    dv, 0);
        chk("pe.empty", empty, 0);
        chk("pe.err",   err, ERR_EN);
        drive(0, 0, 1, 0);
        tick();
        chk("pe.data",  dout, 10'h055);
        chk("pe.count0", count, 0);

        // Push while full without pop: dropped.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 10'(8'h60 + i));
            tick();
        end
        drive(0, 1, 0, 10'h3FF);
        chk("ovf.wren", wr_en, 0);
        tick();
        chk("ovf.count", count, 8);
        chk("ovf.full",  full, 1);
        chk("ovf.err",   err, ERR_EN);

        // Reset mid-operation while pushing.
        drive(1, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 10'(8'h70 + i));
            tick();
        end
        chk("pre.count", count, 5);
        drive(1, 1, 0, 10'h0AA);
        tick();
        drive(0, 0, 0, 0);
        chk_reset_vals();
        drive(0, 0, 1, 0);
        chk("post.rden", rd_en, 0);
        tick();
        chk("post.dv",    dv, 0);
        chk("post.count", count, 0);
        chk("post.empty", empty, 1);
        drive(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
